// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 word multiplexer (N = 2**SEL_W) built as a
// binary 2:1 tree with one register stage per tree level (latency SEL_W),
// valid/ready handshake on both sides, per-stage backpressure and a
// synchronous flush.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush, clears every stage valid, drops input
//   in_valid   src_in/sel valid this cycle
//   in_ready   block accepts input this cycle (combinational from out_ready)
//   sel        index of the word to forward
//   src_in     N flattened WIDTH-bit words, word 0 in the LSBs
//   out_valid  z holds a valid result
//   out_ready  downstream accepts z this cycle
//   z          selected word
//   stall_cnt  saturating count of out_valid & !out_ready cycles
//              (only when MUX_STALL_CNT_EN is defined)
//
// Optional feature macro: MUX_STALL_CNT_EN
module mux_tree_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_W-1:0]              sel,
    input  logic [(WIDTH<<SEL_W)-1:0]     src_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              z
`ifdef MUX_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int unsigned N = 1 << SEL_W;

    logic [SEL_W-1:0] valid;
    logic [SEL_W:0]   ready;

    assign ready[SEL_W] = out_ready;
    assign in_ready     = ready[0];

    for (genvar k = 0; k < SEL_W; k++) begin : g_stage
        localparam int unsigned NW = N >> (k + 1);

        logic [NW*WIDTH-1:0]   data_q;
        logic [NW*WIDTH-1:0]   data_nxt;
        logic [2*NW*WIDTH-1:0] up_data;
        logic                  up_bit;
        logic                  up_valid;
        logic                  vld_q;
        logic                  accept;

        // Upstream source: the raw inputs for the first level, else the previous stage
        if (k == 0) begin : g_first
            assign up_data  = src_in;
            assign up_bit   = sel[0];
            assign up_valid = in_valid;
        end else begin : g_inner
            assign up_data  = g_stage[k-1].data_q;
            assign up_bit   = g_stage[k-1].g_rsel.rsel_q[0];
            assign up_valid = g_stage[k-1].vld_q;
        end

        assign ready[k] = !vld_q | ready[k+1];
        assign valid[k] = vld_q;
        // Input offered during a flush cycle is dropped, never captured
        assign accept   = up_valid & ready[k] & !flush;

        // Pairwise 2:1 selection of the upstream words
        always_comb begin
            data_nxt = '0;
            for (int j = 0; j < int'(NW); j++) begin
                data_nxt[j*WIDTH +: WIDTH] = up_bit ? up_data[(2*j+1)*WIDTH +: WIDTH]
                                                    : up_data[(2*j)*WIDTH +: WIDTH];
            end
        end

        // Stage valid: cleared by flush, follows upstream whenever this stage can take
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (flush) begin
                vld_q <= 1'b0;
            end else if (ready[k]) begin
                vld_q <= up_valid;
            end
        end

        // Stage data: updates only on an accepted transfer
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (accept) begin
                data_q <= data_nxt;
            end
        end

        // Residual select bits still needed by later levels (none after the last)
        if (k < SEL_W - 1) begin : g_rsel
            localparam int unsigned RW = SEL_W - k - 1;

            logic [RW-1:0] rsel_q;
            logic [RW-1:0] rsel_up;

            if (k == 0) begin : g_src
                assign rsel_up = sel[SEL_W-1:1];
            end else begin : g_prev
                assign rsel_up = g_stage[k-1].g_rsel.rsel_q[RW:1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsel_q <= '0;
                end else if (accept) begin
                    rsel_q <= rsel_up;
                end
            end
        end
    end

    assign out_valid = valid[SEL_W-1];
    assign z         = g_stage[SEL_W-1].data_q;

`ifdef MUX_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating output-stall counter; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed self-checking bench for mux_tree_pipe (WIDTH=32, SEL_W=3).
// Word k of src_in is 32'hA0+k, so the expected z for sel=k is 32'hA0+k.
module tb_mux_tree_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned N     = 1 << SEL_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     sel;
    logic [N*WIDTH-1:0]   src_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     z;
`ifdef MUX_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mux_tree_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .src_in    (src_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
`ifdef MUX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s);
        in_valid = 1'b1;
        sel      = SEL_W'(s);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = '0;
        for (int k = 0; k < int'(N); k++) src_in[k*WIDTH +: WIDTH] = 32'hA0 + 32'(k);

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", z, 32'd0);
`ifdef MUX_STALL_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Streaming: sel 0..7 back to back, output after 3 stages, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = (i < 8);
            sel      = SEL_W'(i);
            step();
            if (i >= 2 && i <= 9) begin
                check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
                check($sformatf("stream_z_%0d", i), z, 32'hA0 + 32'(i - 2));
            end else begin
                check($sformatf("stream_idle_%0d", i), 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;

        // Backpressure: fill with 5,2,7 then stall 4 cycles
        out_ready = 1'b0;
        push(5);
        push(2);
        push(7);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_z_%0d", i), z, 32'hA5);
            step();
        end
        out_ready = 1'b1;
        check("bp_drain0", z, 32'hA5);
        step();
        check("bp_drain1", z, 32'hA2);
        check("bp_drain1_v", 32'(out_valid), 32'd1);
        step();
        check("bp_drain2", z, 32'hA7);
        check("bp_drain2_v", 32'(out_valid), 32'd1);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Bubble collapse: lone word advances under stall, second word still accepted
        out_ready = 1'b0;
        push(6);
        step();
        step();
        check("bub_valid", 32'(out_valid), 32'd1);
        check("bub_z", z, 32'hA6);
        check("bub_in_ready", 32'(in_ready), 32'd1);
        push(3);
        check("bub_hold_z", z, 32'hA6);
        check("bub_hold_v", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        step();
        check("bub_second_v", 32'(out_valid), 32'd1);
        check("bub_second_z", z, 32'hA3);
        step();
        check("bub_empty", 32'(out_valid), 32'd0);

        // Flush with a full pipe and input offered
        out_ready = 1'b0;
        push(0);
        push(1);
        push(2);
        check("fl_full_in_ready", 32'(in_ready), 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        sel      = SEL_W'(4);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("fl_quiet_%0d", i), 32'(out_valid), 32'd0);
        end

        // Flush while in_ready=1: the flush-cycle input is still dropped
        push(1);
        check("fl2_in_ready", 32'(in_ready), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        sel      = SEL_W'(4);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fl2_quiet_%0d", i), 32'(out_valid), 32'd0);
            step();
        end

        // Asynchronous reset mid-stream
        push(3);
        push(4);
        push(5);
        check("ar_pre_z", z, 32'hA3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_z", z, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        sel      = SEL_W'(1);
        step();
        in_valid = 1'b0;
        check("ar_lat1", 32'(out_valid), 32'd0);
        step();
        check("ar_lat2", 32'(out_valid), 32'd0);
        step();
        check("ar_out_v", 32'(out_valid), 32'd1);
        check("ar_out_z", z, 32'hA1);

`ifdef MUX_STALL_CNT_EN
        // Stall counter: 10 stall cycles, flush keeps it, then saturation
        out_ready = 1'b0;
        check("sc_start", 32'(stall_cnt), 32'd0);
        repeat (10) step();
        check("sc_ten", 32'(stall_cnt), 32'd10);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("sc_after_flush", 32'(stall_cnt), 32'd10);
        out_ready = 1'b0;
        push(2);
        step();
        step();
        repeat (70000) step();
        check("sc_sat", 32'(stall_cnt), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
